fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Control block for the fetch stage. Each cycle it drives the fetch PC-update controls
//  (pcjumpenable/pcchange/pclocation). It arbitrates redirect requests from decode and
//  execute, holds the PC on stall or halt, and inserts flush bubbles after every redirect.
//  It also counts redirects for performance monitoring.
// PARAMETERS
//  PC_W         20      PC width; matches the 20-bit fetch PC
//  OFF_W        9       signed relative branch offset width
//  FLUSH_DEPTH  2       bubble cycles after a redirect (1..7)
//  RESET_VECTOR 20'h0   PC loaded on leaving reset
//  TRAP_VECTOR  20'h10  PC loaded on trap (FETCH_SEQ_TRAP_EN only)
// PORTS
//  clock            in   1      system clock, rising edge
//  reset_n          in   1      asynchronous, active-low reset
//  stall            in   1      decode hazard; hold PC
//  ex_br_valid      in   1      execute taken branch
//  ex_br_offset     in   OFF_W  signed PC-relative offset
//  dec_jmp_valid    in   1      decode absolute jump
//  dec_jmp_target   in   PC_W   absolute target
//  halt_req         in   1      enter HALT; raised only with pipeline drained
//  resume           in   1      leave HALT
//  pcjumpenable     out  3      0=INC 1=REL 2=ABS 3=HOLD
//  pcchange         out  OFF_W  offset when REL, else 0
//  pclocation       out  PC_W   target when ABS, else 0
//  flush            out  1      registered; decode must discard its instruction
//  halted           out  1      registered; state==HALT
//  redirect_count   out  16     saturating count of accepted redirects
//  trap_req/trap_ack in/out 1   present only with FETCH_SEQ_TRAP_EN
// BEHAVIOUR
//  - PC controls are combinational from state and inputs; the fetch PC updates on the next edge.
//  - States: BOOT, RUN, FLUSH, HALT. Reset forces BOOT, flush_cnt=0, flush=0, halted=0, count=0.
//  - While reset_n=0: pcjumpenable=HOLD, pcchange=0, pclocation=0.
//  - BOOT: drive ABS/RESET_VECTOR for one cycle, then go to FLUSH with cnt=FLUSH_DEPTH; not counted.
//  - RUN priority, highest first:
//      ex_br -> REL, go to FLUSH.
//      dec_jmp -> ABS, go to FLUSH. A simultaneous dec_jmp is younger and is dropped.
//      halt_req -> HOLD, go to HALT.
//      stall -> HOLD, stay in RUN.
//      otherwise INC.
//  - FLUSH: flush=1; cnt decrements each cycle; go to RUN when cnt==1.
//      ex_br -> REL and reload cnt=FLUSH_DEPTH.
//      dec_jmp and stall are ignored (wrong path); otherwise INC.
//      halt_req is not latched; the requester holds it until it is taken in RUN.
//  - HALT: HOLD; all redirect inputs ignored; resume -> RUN, drives HOLD that cycle.
//  - Every ex_br or dec_jmp accepted in RUN/FLUSH increments redirect_count; it saturates at 16'hFFFF.
//  - REL offset is sign-extended by fetch. ABS target is passed through unmodified.
//  - Reset asserted mid-FLUSH or mid-HALT aborts immediately to BOOT; there is no residual flush.
// CONFIGURATION
//  FETCH_SEQ_TRAP_EN defined:
//    trap_req is top priority in every non-BOOT state, including HALT (wakes it).
//    It drives ABS/TRAP_VECTOR, goes to FLUSH, counts as a redirect, and pulses trap_ack for 1 cycle.
//  Undefined: trap ports absent; trap logic is not built.
// STRUCTURE
//  fetch_pkg: PCSEL_INC/REL/ABS/HOLD encodings; state encodings BOOT/RUN/FLUSH/HALT.
//  Sub-module redirect_arbiter: combinational fixed-priority select of
//    trap/ex_br/dec_jmp/halt/stall -> {pcsel, pcchange, pclocation, accept}.
//  The top level holds the FSM, flush counter and redirect counter.
// TESTING
//  1. Release reset -> 1 cycle ABS 20'h0, then 2 cycles flush=1 with INC, then RUN INC.
//  2. RUN, ex_br_valid + offset 9'h1F0 with dec_jmp_valid -> REL 9'h1F0 only; count 0->1; flush 2 cycles.
//  3. FLUSH cycle 1, dec_jmp_valid -> ignored (INC). ex_br_valid in the same window -> REL; flush lasts 2 more cycles.
//  4. RUN stall held 3 cycles -> HOLD x3, no flush. halt_req -> HALT; resume -> RUN, HOLD then INC.
//  5. Preload count 16'hFFFE, issue 3 redirects -> count sticks at 16'hFFFF.
//  6. TRAP_EN: trap_req during HALT -> ABS TRAP_VECTOR, trap_ack 1 cycle, then FLUSH; reset mid-FLUSH -> BOOT.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared encodings for the fetch sequencer:
//   pcsel_e       - PC-update select driven on pcjumpenable (INC/REL/ABS/HOLD)
//   fetch_state_e - sequencer FSM states (BOOT/RUN/FLUSH/HALT)
//   arb_sel_e     - which request the redirect arbiter picked this cycle
//   sat_inc16     - saturating 16-bit increment for the redirect counter
// Optional feature macro used by the files importing this package:
//   FETCH_SEQ_TRAP_EN
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [2:0] {
        PCSEL_INC  = 3'd0,
        PCSEL_REL  = 3'd1,
        PCSEL_ABS  = 3'd2,
        PCSEL_HOLD = 3'd3
    } pcsel_e;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

    typedef enum logic [2:0] {
        SEL_NONE  = 3'd0,
        SEL_TRAP  = 3'd1,
        SEL_BR    = 3'd2,
        SEL_JMP   = 3'd3,
        SEL_HALT  = 3'd4,
        SEL_STALL = 3'd5
    } arb_sel_e;

    localparam int REDIRECT_CNT_W = 16;

    // Counter sticks at all-ones instead of wrapping.
    function automatic logic [REDIRECT_CNT_W-1:0] sat_inc16(
        input logic [REDIRECT_CNT_W-1:0] value
    );
        if (value == {REDIRECT_CNT_W{1'b1}}) begin
            return value;
        end
        return value + 1'b1;
    endfunction

endpackage : fetch_pkg

// File: rtl/fetch_sequencer_arbiter.sv
// -----------------------------------------------------------------------------
// redirect_arbiter
// Purely combinational fixed-priority select between the sources that can move
// the fetch PC. Priority, highest first: trap, execute branch, decode jump,
// halt request, stall. Each source is qualified by an enable from the FSM so
// that the same arbiter serves every state (e.g. decode jumps are masked while
// flushing because they are on the wrong path).
//
// Ports
//   en_*_i            in  1      state-dependent source enables
//   trap_req_i        in  1      trap request (tied low when traps are not built)
//   ex_br_valid_i     in  1      taken branch from execute
//   ex_br_offset_i    in  OFF_W  signed PC-relative offset
//   dec_jmp_valid_i   in  1      absolute jump from decode
//   dec_jmp_target_i  in  PC_W   absolute jump target
//   halt_req_i        in  1      request to enter HALT
//   stall_i           in  1      decode hazard
//   pcsel_o           out 3      selected PC update (INC when nothing wins)
//   pcchange_o        out OFF_W  offset when REL, else 0
//   pclocation_o      out PC_W   target when ABS, else 0
//   accept_o          out 1      a redirect (trap/branch/jump) was taken
//   kind_o            out 3      which source won
// Optional feature macro: FETCH_SEQ_TRAP_EN (handled by the instantiating top)
// -----------------------------------------------------------------------------
module redirect_arbiter
    import fetch_pkg::*;
#(
    parameter int              PC_W        = 20,
    parameter int              OFF_W       = 9,
    parameter logic [PC_W-1:0] TRAP_VECTOR = 20'h10
) (
    input  logic              en_trap_i,
    input  logic              en_br_i,
    input  logic              en_jmp_i,
    input  logic              en_halt_i,
    input  logic              en_stall_i,
    input  logic              trap_req_i,
    input  logic              ex_br_valid_i,
    input  logic [OFF_W-1:0]  ex_br_offset_i,
    input  logic              dec_jmp_valid_i,
    input  logic [PC_W-1:0]   dec_jmp_target_i,
    input  logic              halt_req_i,
    input  logic              stall_i,
    output pcsel_e            pcsel_o,
    output logic [OFF_W-1:0]  pcchange_o,
    output logic [PC_W-1:0]   pclocation_o,
    output logic              accept_o,
    output arb_sel_e          kind_o
);

    always_comb begin
        pcsel_o      = PCSEL_INC;
        pcchange_o   = '0;
        pclocation_o = '0;
        accept_o     = 1'b0;
        kind_o       = SEL_NONE;

        if (en_trap_i && trap_req_i) begin
            pcsel_o      = PCSEL_ABS;
            pclocation_o = TRAP_VECTOR;
            accept_o     = 1'b1;
            kind_o       = SEL_TRAP;
        end else if (en_br_i && ex_br_valid_i) begin
            // Execute is older than decode, so a concurrent decode jump is dropped.
            pcsel_o    = PCSEL_REL;
            pcchange_o = ex_br_offset_i;
            accept_o   = 1'b1;
            kind_o     = SEL_BR;
        end else if (en_jmp_i && dec_jmp_valid_i) begin
            pcsel_o      = PCSEL_ABS;
            pclocation_o = dec_jmp_target_i;
            accept_o     = 1'b1;
            kind_o       = SEL_JMP;
        end else if (en_halt_i && halt_req_i) begin
            pcsel_o = PCSEL_HOLD;
            kind_o  = SEL_HALT;
        end else if (en_stall_i && stall_i) begin
            pcsel_o = PCSEL_HOLD;
            kind_o  = SEL_STALL;
        end
    end

endmodule : redirect_arbiter

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Fetch-stage control: drives the PC-update controls every cycle, arbitrates
// redirects from decode/execute (and optionally traps), holds the PC on stall
// or halt, inserts FLUSH_DEPTH bubble cycles after every redirect and counts
// accepted redirects.
//
// Ports
//   clock            in   1      system clock, rising edge
//   reset_n          in   1      asynchronous active-low reset
//   stall            in   1      decode hazard; hold PC
//   ex_br_valid      in   1      execute taken branch
//   ex_br_offset     in   OFF_W  signed PC-relative offset
//   dec_jmp_valid    in   1      decode absolute jump
//   dec_jmp_target   in   PC_W   absolute target
//   halt_req         in   1      enter HALT (held by requester until taken)
//   resume           in   1      leave HALT
//   pcjumpenable     out  3      0=INC 1=REL 2=ABS 3=HOLD (combinational)
//   pcchange         out  OFF_W  offset when REL, else 0
//   pclocation       out  PC_W   target when ABS, else 0
//   flush            out  1      registered; decode discards its instruction
//   halted           out  1      registered; FSM is in HALT
//   redirect_count   out  16     saturating count of accepted redirects
//   trap_req         in   1      (FETCH_SEQ_TRAP_EN only) trap request
//   trap_ack         out  1      (FETCH_SEQ_TRAP_EN only) high in the cycle the
//                                trap redirect is driven
// Optional feature macro: FETCH_SEQ_TRAP_EN
// FLUSH_DEPTH must lie in 1..7 (3-bit bubble counter).
// -----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int              PC_W         = 20,
    parameter int              OFF_W        = 9,
    parameter int              FLUSH_DEPTH  = 2,
    parameter logic [PC_W-1:0] RESET_VECTOR = '0,
    parameter logic [PC_W-1:0] TRAP_VECTOR  = 20'h10
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              ex_br_valid,
    input  logic [OFF_W-1:0]  ex_br_offset,
    input  logic              dec_jmp_valid,
    input  logic [PC_W-1:0]   dec_jmp_target,
    input  logic              halt_req,
    input  logic              resume,
    output logic [2:0]        pcjumpenable,
    output logic [OFF_W-1:0]  pcchange,
    output logic [PC_W-1:0]   pclocation,
    output logic              flush,
    output logic              halted,
    output logic [15:0]       redirect_count
`ifdef FETCH_SEQ_TRAP_EN
    ,
    input  logic              trap_req,
    output logic              trap_ack
`endif
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_DEPTH);

    fetch_state_e       state_q, state_d;
    logic [2:0]         flush_cnt_q, flush_cnt_d;
    logic               flush_q;
    logic               halted_q;
    logic [15:0]        redirect_count_q;

    pcsel_e             pcsel_c;
    logic [OFF_W-1:0]   pcchange_c;
    logic [PC_W-1:0]    pclocation_c;
    logic               count_inc;
    logic               trap_ack_c;
    logic               trap_req_int;

    logic               en_trap, en_br, en_jmp, en_halt, en_stall;
    pcsel_e             arb_pcsel;
    logic [OFF_W-1:0]   arb_pcchange;
    logic [PC_W-1:0]    arb_pclocation;
    logic               arb_accept;
    arb_sel_e           arb_kind;

`ifdef FETCH_SEQ_TRAP_EN
    assign trap_req_int = trap_req;
`else
    // Without traps the request is a constant zero, so the trap branch of the
    // arbiter folds away.
    assign trap_req_int = 1'b0;
`endif

    // Source enables depend only on the registered state, which keeps the
    // arbiter free of any combinational loop through the FSM.
    assign en_trap  = (state_q != BOOT);
    assign en_br    = (state_q == RUN) || (state_q == FLUSH);
    assign en_jmp   = (state_q == RUN);
    assign en_halt  = (state_q == RUN);
    assign en_stall = (state_q == RUN);

    redirect_arbiter #(
        .PC_W        (PC_W),
        .OFF_W       (OFF_W),
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_arbiter (
        .en_trap_i        (en_trap),
        .en_br_i          (en_br),
        .en_jmp_i         (en_jmp),
        .en_halt_i        (en_halt),
        .en_stall_i       (en_stall),
        .trap_req_i       (trap_req_int),
        .ex_br_valid_i    (ex_br_valid),
        .ex_br_offset_i   (ex_br_offset),
        .dec_jmp_valid_i  (dec_jmp_valid),
        .dec_jmp_target_i (dec_jmp_target),
        .halt_req_i       (halt_req),
        .stall_i          (stall),
        .pcsel_o          (arb_pcsel),
        .pcchange_o       (arb_pcchange),
        .pclocation_o     (arb_pclocation),
        .accept_o         (arb_accept),
        .kind_o           (arb_kind)
    );

    // Next-state and PC-control decode.
    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        pcsel_c      = PCSEL_HOLD;
        pcchange_c   = '0;
        pclocation_c = '0;

        case (state_q)
            BOOT: begin
                pcsel_c      = PCSEL_ABS;
                pclocation_c = RESET_VECTOR;
                state_d      = FLUSH;
                flush_cnt_d  = FLUSH_LOAD;
            end

            RUN: begin
                pcsel_c      = arb_pcsel;
                pcchange_c   = arb_pcchange;
                pclocation_c = arb_pclocation;
                if (arb_accept) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end else if (arb_kind == SEL_HALT) begin
                    state_d = HALT;
                end
            end

            FLUSH: begin
                // Decode jumps and stalls are masked here, so the arbiter
                // falls back to INC unless a branch or trap wins.
                pcsel_c      = arb_pcsel;
                pcchange_c   = arb_pcchange;
                pclocation_c = arb_pclocation;
                if (arb_accept) begin
                    flush_cnt_d = FLUSH_LOAD;
                end else if (flush_cnt_q == 3'd1) begin
                    state_d     = RUN;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end

            HALT: begin
                // Only a trap can redirect out of HALT; resume holds the PC for
                // the exit cycle and fetch restarts with INC in RUN.
                if (arb_accept) begin
                    pcsel_c      = arb_pcsel;
                    pcchange_c   = arb_pcchange;
                    pclocation_c = arb_pclocation;
                    state_d      = FLUSH;
                    flush_cnt_d  = FLUSH_LOAD;
                end else if (resume) begin
                    state_d = RUN;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Arbiter enables are all low in BOOT, so the boot load is never counted.
    assign count_inc  = arb_accept;
    assign trap_ack_c = arb_accept && (arb_kind == SEL_TRAP);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= BOOT;
            flush_cnt_q      <= '0;
            flush_q          <= 1'b0;
            halted_q         <= 1'b0;
            redirect_count_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            flush_q     <= (state_d == FLUSH);
            halted_q    <= (state_d == HALT);
            if (count_inc) begin
                redirect_count_q <= sat_inc16(redirect_count_q);
            end
        end
    end

    // PC controls are forced to HOLD/0 while reset is asserted, independent of
    // the clock.
    assign pcjumpenable   = reset_n ? pcsel_c      : PCSEL_HOLD;
    assign pcchange       = reset_n ? pcchange_c   : '0;
    assign pclocation     = reset_n ? pclocation_c : '0;
    assign flush          = flush_q;
    assign halted         = halted_q;
    assign redirect_count = redirect_count_q;

`ifdef FETCH_SEQ_TRAP_EN
    assign trap_ack = reset_n && trap_ack_c;
`else
    logic unused_trap;
    assign unused_trap = trap_ack_c;
`endif

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed bench for fetch_sequencer with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// Optional feature macro: FETCH_SEQ_TRAP_EN (enables the trap scenario).
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam logic [2:0] P_INC  = 3'd0;
    localparam logic [2:0] P_REL  = 3'd1;
    localparam logic [2:0] P_ABS  = 3'd2;
    localparam logic [2:0] P_HOLD = 3'd3;

    logic        clock;
    logic        reset_n;
    logic        stall;
    logic        ex_br_valid;
    logic [8:0]  ex_br_offset;
    logic        dec_jmp_valid;
    logic [19:0] dec_jmp_target;
    logic        halt_req;
    logic        resume;
    logic [2:0]  pcjumpenable;
    logic [8:0]  pcchange;
    logic [19:0] pclocation;
    logic        flush;
    logic        halted;
    logic [15:0] redirect_count;
`ifdef FETCH_SEQ_TRAP_EN
    logic        trap_req;
    logic        trap_ack;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fetch_sequencer dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .stall          (stall),
        .ex_br_valid    (ex_br_valid),
        .ex_br_offset   (ex_br_offset),
        .dec_jmp_valid  (dec_jmp_valid),
        .dec_jmp_target (dec_jmp_target),
        .halt_req       (halt_req),
        .resume         (resume),
        .pcjumpenable   (pcjumpenable),
        .pcchange       (pcchange),
        .pclocation     (pclocation),
        .flush          (flush),
        .halted         (halted),
        .redirect_count (redirect_count)
`ifdef FETCH_SEQ_TRAP_EN
        ,
        .trap_req       (trap_req),
        .trap_ack       (trap_ack)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic log_step(input string name);
        $display("[%0t] step %s: pje=%0d chg=0x%0h loc=0x%0h flush=%0b halted=%0b cnt=0x%0h",
                 $time, name, pcjumpenable, pcchange, pclocation, flush, halted, redirect_count);
    endtask

    task automatic clear_inputs();
        stall          = 1'b0;
        ex_br_valid    = 1'b0;
        ex_br_offset   = '0;
        dec_jmp_valid  = 1'b0;
        dec_jmp_target = '0;
        halt_req       = 1'b0;
        resume         = 1'b0;
`ifdef FETCH_SEQ_TRAP_EN
        trap_req       = 1'b0;
`endif
    endtask

    // Watchdog: the run is a fixed number of cycles, this only guards a hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clock);
        #1;
        log_step("reset");
        check_eq("rst_pje",   32'(pcjumpenable),   32'(P_HOLD));
        check_eq("rst_chg",   32'(pcchange),       32'h0);
        check_eq("rst_loc",   32'(pclocation),     32'h0);
        check_eq("rst_flush", 32'(flush),          32'h0);
        check_eq("rst_halt",  32'(halted),         32'h0);
        check_eq("rst_cnt",   32'(redirect_count), 32'h0);

        // 1: boot sequence
        @(negedge clock); reset_n = 1'b1; #1;
        log_step("boot");
        check_eq("boot_pje",  32'(pcjumpenable), 32'(P_ABS));
        check_eq("boot_loc",  32'(pclocation),   32'h0);
        check_eq("boot_fl",   32'(flush),        32'h0);
        @(negedge clock); #1;
        log_step("boot_flush1");
        check_eq("bf1_pje",   32'(pcjumpenable), 32'(P_INC));
        check_eq("bf1_fl",    32'(flush),        32'h1);
        @(negedge clock); #1;
        log_step("boot_flush2");
        check_eq("bf2_fl",    32'(flush),        32'h1);
        check_eq("bf2_pje",   32'(pcjumpenable), 32'(P_INC));

        // 2: branch beats simultaneous jump
        @(negedge clock); #1;
        log_step("run");
        check_eq("run_pje",   32'(pcjumpenable), 32'(P_INC));
        check_eq("run_fl",    32'(flush),        32'h0);
        check_eq("run_cnt",   32'(redirect_count), 32'h0);
        ex_br_valid = 1'b1; ex_br_offset = 9'h1F0;
        dec_jmp_valid = 1'b1; dec_jmp_target = 20'hABCDE; #1;
        log_step("br_and_jmp");
        check_eq("br_pje",    32'(pcjumpenable), 32'(P_REL));
        check_eq("br_chg",    32'(pcchange),     32'h1F0);
        check_eq("br_loc",    32'(pclocation),   32'h0);

        // 3: in FLUSH, jump and stall ignored; branch reloads the bubble count
        @(negedge clock); clear_inputs();
        dec_jmp_valid = 1'b1; dec_jmp_target = 20'hABCDE; stall = 1'b1; #1;
        log_step("flush_jmp");
        check_eq("fj_pje",    32'(pcjumpenable),   32'(P_INC));
        check_eq("fj_loc",    32'(pclocation),     32'h0);
        check_eq("fj_fl",     32'(flush),          32'h1);
        check_eq("fj_cnt",    32'(redirect_count), 32'h1);
        @(negedge clock); clear_inputs();
        ex_br_valid = 1'b1; ex_br_offset = 9'h005; #1;
        log_step("flush_br");
        check_eq("fb_pje",    32'(pcjumpenable),   32'(P_REL));
        check_eq("fb_chg",    32'(pcchange),       32'h005);
        check_eq("fb_cnt",    32'(redirect_count), 32'h1);
        @(negedge clock); clear_inputs(); #1;
        log_step("reflush1");
        check_eq("rf1_fl",    32'(flush),          32'h1);
        check_eq("rf1_cnt",   32'(redirect_count), 32'h2);
        @(negedge clock); #1;
        log_step("reflush2");
        check_eq("rf2_fl",    32'(flush),          32'h1);

        // 4: stall x3, then halt / resume
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); stall = 1'b1; #1;
            log_step("stall");
            check_eq("st_pje", 32'(pcjumpenable), 32'(P_HOLD));
            check_eq("st_fl",  32'(flush),        32'h0);
        end
        @(negedge clock); stall = 1'b0; halt_req = 1'b1; #1;
        log_step("halt_req");
        check_eq("hr_pje",    32'(pcjumpenable), 32'(P_HOLD));
        check_eq("hr_halt",   32'(halted),       32'h0);
        @(negedge clock); halt_req = 1'b0; ex_br_valid = 1'b1; ex_br_offset = 9'h0AA; #1;
        log_step("halted_br");
        check_eq("hb_pje",    32'(pcjumpenable), 32'(P_HOLD));
        check_eq("hb_chg",    32'(pcchange),     32'h0);
        check_eq("hb_halt",   32'(halted),       32'h1);
        @(negedge clock); clear_inputs(); resume = 1'b1; #1;
        log_step("resume");
        check_eq("rs_pje",    32'(pcjumpenable),   32'(P_HOLD));
        check_eq("rs_halt",   32'(halted),         32'h1);
        check_eq("rs_cnt",    32'(redirect_count), 32'h2);
        @(negedge clock); resume = 1'b0; #1;
        log_step("after_resume");
        check_eq("ar_pje",    32'(pcjumpenable), 32'(P_INC));
        check_eq("ar_halt",   32'(halted),       32'h0);

`ifdef FETCH_SEQ_TRAP_EN
        // 6: trap wakes HALT
        @(negedge clock); halt_req = 1'b1; #1;
        log_step("halt_req2");
        check_eq("hr2_pje",   32'(pcjumpenable), 32'(P_HOLD));
        @(negedge clock); halt_req = 1'b0; trap_req = 1'b1; #1;
        log_step("trap");
        check_eq("tr_halt",   32'(halted),       32'h1);
        check_eq("tr_pje",    32'(pcjumpenable), 32'(P_ABS));
        check_eq("tr_loc",    32'(pclocation),   32'h10);
        check_eq("tr_ack",    32'(trap_ack),     32'h1);
        @(negedge clock); trap_req = 1'b0; #1;
        log_step("trap_flush");
        check_eq("tf_fl",     32'(flush),          32'h1);
        check_eq("tf_halt",   32'(halted),         32'h0);
        check_eq("tf_ack",    32'(trap_ack),       32'h0);
        check_eq("tf_cnt",    32'(redirect_count), 32'h3);
`else
        @(negedge clock); ex_br_valid = 1'b1; ex_br_offset = 9'h100; #1;
        log_step("br_neg");
        check_eq("bn_pje",    32'(pcjumpenable), 32'(P_REL));
        check_eq("bn_chg",    32'(pcchange),     32'h100);
        @(negedge clock); clear_inputs(); #1;
        log_step("br_neg_flush");
        check_eq("bnf_fl",    32'(flush),          32'h1);
        check_eq("bnf_cnt",   32'(redirect_count), 32'h3);
`endif

        // Reset in the middle of FLUSH aborts straight back to BOOT
        reset_n = 1'b0; #1;
        log_step("reset_mid_flush");
        check_eq("rm_fl",     32'(flush),          32'h0);
        check_eq("rm_pje",    32'(pcjumpenable),   32'(P_HOLD));
        check_eq("rm_cnt",    32'(redirect_count), 32'h0);
        @(negedge clock); reset_n = 1'b1; #1;
        log_step("reboot");
        check_eq("rb_pje",    32'(pcjumpenable), 32'(P_ABS));
        check_eq("rb_fl",     32'(flush),        32'h0);

        // 5: saturation - a branch held high is accepted every cycle in FLUSH
        @(negedge clock); ex_br_valid = 1'b1; ex_br_offset = 9'h002;
        repeat (65534) @(negedge clock);
        #1;
        log_step("sat_fffe");
        check_eq("sat_fffe",  32'(redirect_count), 32'hFFFE);
        check_eq("sat_pje",   32'(pcjumpenable),   32'(P_REL));
        @(negedge clock); #1;
        log_step("sat_ffff");
        check_eq("sat_ffff",  32'(redirect_count), 32'hFFFF);
        repeat (2) @(negedge clock);
        #1;
        log_step("sat_hold");
        check_eq("sat_hold",  32'(redirect_count), 32'hFFFF);
        clear_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_sequencer
